// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: scoreboard-based operand forwarding, load-use stall and branch flush control
module hazard_fwd_unit #(
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2,
  parameter int BR_STAGE   = 1,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    id_valid,
  input  logic [REG_AW-1:0]       id_rs,
  input  logic [REG_AW-1:0]       id_rt,
  input  logic                    id_uses_rs,
  input  logic                    id_uses_rt,
  input  logic [REG_AW-1:0]       id_rd,
  input  logic                    id_regwrite,
  input  logic                    id_memread,
  input  logic                    br_taken,
  input  logic [DATA_W-1:0]       rf_rs_data,
  input  logic [DATA_W-1:0]       rf_rt_data,
  input  logic [DEPTH*DATA_W-1:0] stage_data,
  output logic [DATA_W-1:0]       id_rs_data,
  output logic [DATA_W-1:0]       id_rt_data,
  output logic                    stall,
  output logic                    flush_if_id,
  output logic                    flush_id_ex,
  output logic [DEPTH-1:0]        flush_mask,
  output logic [CNT_W-1:0]        stall_cnt,
  output logic [CNT_W-1:0]        flush_cnt
);
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              is_load;
  } ent_t;
  ent_t [DEPTH-1:0] sb, sb_nxt;
  logic [DEPTH-1:0] live;
  logic rs_haz, rt_haz;
  // Scan oldest to youngest so the lowest matching entry has the final say.
  function automatic logic [DATA_W:0] resolve(
    input logic                    uses,
    input logic [REG_AW-1:0]       r,
    input logic [DATA_W-1:0]       rf,
    input ent_t [DEPTH-1:0]        e,
    input logic [DEPTH-1:0]        lv,
    input logic [DEPTH*DATA_W-1:0] sd
  );
    logic [DATA_W:0] res;
    res = {1'b0, rf};
    for (int k = DEPTH - 1; k >= 0; k--)
      if (uses && r != '0 && lv[k] && e[k].rd == r)
        res = {e[k].is_load && (k < LOAD_STAGE), sd[k*DATA_W +: DATA_W]};
    return res;
  endfunction
  for (genvar k = 0; k < DEPTH; k++) begin : g_e
    assign flush_mask[k] = br_taken && (k < BR_STAGE);
    assign live[k] = sb[k].valid && sb[k].regwrite && sb[k].rd != '0 && !flush_mask[k];
  end
  assign {rs_haz, id_rs_data} = resolve(id_uses_rs, id_rs, rf_rs_data, sb, live, stage_data);
  assign {rt_haz, id_rt_data} = resolve(id_uses_rt, id_rt, rf_rt_data, sb, live, stage_data);
  assign stall       = id_valid && !br_taken && (rs_haz || rt_haz);
  assign flush_if_id = br_taken;
  assign flush_id_ex = br_taken;
  // Flushed entries are dropped as they shift, so younger-than-branch work never resurfaces.
  always_comb begin
    sb_nxt[0] = {id_valid && !stall && !br_taken, id_rd, id_regwrite, id_memread};
    for (int k = 1; k < DEPTH; k++)
      sb_nxt[k] = flush_mask[k-1] ? '0 : sb[k-1];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sb        <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      sb <= sb_nxt;
      if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (br_taken && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
- Parametrised hazard and forwarding controller for the five-stage pipeline.
- Sits between decode and the EX/MEM/WB stages.
- Keeps its own shift-register scoreboard of in-flight destination registers (one entry per post-decode stage) and resolves decode operands from the youngest in-flight producer.
- Raises load-use stalls; on a taken branch it flushes the younger stages and drops their scoreboard entries.
- Provides saturating stall and flush event counters.

Parameters:
- DATA_W, 32, operand/result width.
- REG_AW, 5, register address width; register 0 is hard-wired zero.
- DEPTH, 3, number of tracked post-decode stages (entry 0 = EX, entry DEPTH-1 = WB).
- LOAD_STAGE, 2, first entry index at which a load's result is valid on stage_data.
- BR_STAGE, 1, entry index of the stage that asserts br_taken.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- id_valid  in  1  decode holds a real instruction.
- id_rs, id_rt  in  REG_AW  decode source registers.
- id_uses_rs, id_uses_rt  in  1  the source is actually read.
- id_rd  in  REG_AW  decode destination after the regdst mux.
- id_regwrite  in  1  decode instruction writes a register.
- id_memread  in  1  decode instruction is a load.
- br_taken  in  1  branch taken, resolved in entry BR_STAGE.
- rf_rs_data, rf_rt_data  in  DATA_W  register file read data.
- stage_data  in  DEPTH*DATA_W  result of each entry's stage; slice k = entry k.
- id_rs_data, id_rt_data  out  DATA_W  resolved operands.
- stall  out  1  hold PC and IF/ID, insert a bubble into ID/EX.
- flush_if_id, flush_id_ex  out  1  squash those pipeline registers.
- flush_mask  out  DEPTH  entries being invalidated this cycle.
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters.

Behaviour:
- Reset:
  - All entries invalid, counters 0.
  - Outputs combinational, so at reset stall=0 and flush_*=0 provided id_valid=0 and br_taken=0.
  - Reset mid-stall clears the stall on the next evaluation.
- Scoreboard entry contents: {valid, rd, regwrite, is_load}. An entry counts as a producer only if valid & regwrite & rd != 0.
- Every clock, with no gating:
  - entry k <= entry k-1 for k >= 1.
  - entry 0 <= decode instruction if id_valid & !stall & !br_taken; otherwise a bubble (valid=0).
  - On br_taken, entries 0..BR_STAGE-1 shift in as invalid. In the same cycle, flush_mask bit k=1 for k < BR_STAGE and flush_if_id = flush_id_ex = 1.
- Operand resolution, per source s in {rs, rt}, combinational:
  - If !uses_s or s == 0: data = rf data (register 0 reads as 0 from the register file).
  - Otherwise find the lowest k with a matching producer.
    - None found: data = rf data.
    - Match that is a load with k < LOAD_STAGE: hazard.
    - Any other match: data = stage_data slice k.
  - Youngest producer wins when several entries match.
- stall = id_valid & !br_taken & (hazard on rs | hazard on rt). br_taken takes priority over stall; a flushed decode never stalls.
- Load-use with the defaults:
  - Load in EX and dependent in ID: 2 stall cycles, then forward from slice 2.
  - Dependent issued one cycle later: 1 stall cycle.
- Counters:
  - stall_cnt += 1 each cycle stall = 1.
  - flush_cnt += 1 each cycle br_taken = 1.
  - Both saturate at all-ones and never wrap.
- No forwarding from a flushed entry: flush_mask entries are treated as invalid for resolution in the same cycle.

Test Plan:
- Reset then idle: rst pulse, id_valid=0 → stall=0, flush_*=0, stall_cnt=flush_cnt=0, operands equal rf data.
- EX forwarding: issue add r3; next cycle decode uses rs=r3, stage_data[0]=0x0000_00AA → id_rs_data=0x0000_00AA, stall=0.
- Youngest wins: r5 written by entry 2 (0x11) and entry 0 (0x22); decode reads r5 → 0x22. A write to r0 is never forwarded.
- Load-use: issue lw r4; next cycle decode reads rt=r4 → stall=1 for exactly 2 cycles, stall_cnt=2, then id_rt_data=stage_data[2].
- Branch flush: br_taken=1 while decode would stall → stall=0, flush_if_id=flush_id_ex=1, flush_mask=3'b001, entry 0 invalid next cycle, flush_cnt=1.
- Saturation: CNT_W=4, hold stall for 20 cycles → stall_cnt=15 and stays at 15.
